output_mem_scheduler: RTL and testbench

OUTPUT_MEM_SCHEDULER -- requirements
Module: output_mem_scheduler

---
 rtl/snn_out_pkg.sv | 22 ++
 rtl/lif_threshold.sv | 26 ++
 rtl/output_mem_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_output_mem_scheduler.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_out_pkg.sv
// Shared defaults and scheduler state encoding for the SNN output stage.
// Imported by output_mem_scheduler and lif_threshold.
package snn_out_pkg;

    localparam int         DEPTH_C_DEF   = 441;
    localparam int         ADDR_C_DEF    = 9;
    localparam int         CONV_W_DEF    = 13;
    localparam int         THRESHOLD_DEF = 64;
    localparam logic [3:0] TS1_SRC_DEF   = 4'd13;

    typedef enum logic [2:0] {
        FILL,
        RD1,
        EV1,
        OUT1,
        RD2,
        EV2,
        OUT2,
        DONE
    } state_e;

endpackage

// File: rtl/lif_threshold.sv
// Combinational LIF fire decision: compare against threshold, subtract on
// fire, saturate the residue to CONV_W bits.
// Ports: val (CONV_W+1 membrane value), fire, residue (CONV_W).
module lif_threshold
    import snn_out_pkg::*;
#(
    parameter int CONV_W    = CONV_W_DEF,
    parameter int THRESHOLD = THRESHOLD_DEF
) (
    input  logic [CONV_W:0]   val,
    output logic              fire,
    output logic [CONV_W-1:0] residue
);

    localparam logic [CONV_W:0] THR = (CONV_W+1)'(THRESHOLD);
    localparam logic [CONV_W:0] SAT = {1'b0, {CONV_W{1'b1}}};

    logic [CONV_W:0] diff;

    always_comb begin
        fire    = (val >= THR);
        diff    = fire ? (val - THR) : val;
        residue = (diff > SAT) ? SAT[CONV_W-1:0] : diff[CONV_W-1:0];
    end

endmodule

// File: rtl/output_mem_scheduler.sv
// Buffers two timesteps of psums in SRAMs, then scans ts1 and ts1+ts2 sums
// through the LIF threshold, emitting a spike stream and writing residues.
// Ports: clk/rst_n; in_* psum handshake; m1_*/m2_* SRAM ports;
// spk_* spike stream; layer_done pulse; busy (not in FILL).
module output_mem_scheduler
    import snn_out_pkg::*;
#(
    parameter int         DEPTH_C   = DEPTH_C_DEF,
    parameter int         ADDR_C    = ADDR_C_DEF,
    parameter int         CONV_W    = CONV_W_DEF,
    parameter int         THRESHOLD = THRESHOLD_DEF,
    parameter logic [3:0] TS1_SRC   = TS1_SRC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_src,
    input  logic [CONV_W-1:0] in_psum,
    output logic              m1_en,
    output logic              m1_we,
    output logic [ADDR_C-1:0] m1_addr,
    output logic [CONV_W-1:0] m1_wdata,
    input  logic [CONV_W-1:0] m1_rdata,
    output logic              m2_en,
    output logic              m2_we,
    output logic [ADDR_C-1:0] m2_addr,
    output logic [CONV_W-1:0] m2_wdata,
    input  logic [CONV_W-1:0] m2_rdata,
    output logic              spk_valid,
    input  logic              spk_ready,
    output logic [ADDR_C-1:0] spk_addr,
    output logic              spk_bit,
    output logic [1:0]        spk_ts,
    output logic              layer_done,
    output logic              busy
);

    localparam logic [ADDR_C-1:0] LAST = ADDR_C'(DEPTH_C - 1);

    state_e            state_q, state_d;
    logic [ADDR_C-1:0] wptr1_q, wptr1_d;
    logic [ADDR_C-1:0] wptr2_q, wptr2_d;
    logic [ADDR_C-1:0] rptr_q, rptr_d;
    logic              full1_q, full1_d;
    logic              full2_q, full2_d;
    logic [CONV_W:0]   val_q, val_d;

    logic              fire;
    logic [CONV_W-1:0] residue;
    logic              is_ts1;
    logic              accept;
    logic              last;

    lif_threshold #(
        .CONV_W   (CONV_W),
        .THRESHOLD(THRESHOLD)
    ) u_lif (
        .val    (val_q),
        .fire   (fire),
        .residue(residue)
    );

    always_comb begin
        state_d    = state_q;
        wptr1_d    = wptr1_q;
        wptr2_d    = wptr2_q;
        rptr_d     = rptr_q;
        full1_d    = full1_q;
        full2_d    = full2_q;
        val_d      = val_q;
        in_ready   = 1'b0;
        m1_en      = 1'b0;
        m1_we      = 1'b0;
        m1_addr    = rptr_q;
        m1_wdata   = residue;
        m2_en      = 1'b0;
        m2_we      = 1'b0;
        m2_addr    = rptr_q;
        m2_wdata   = residue;
        spk_valid  = 1'b0;
        spk_addr   = rptr_q;
        spk_bit    = fire;
        spk_ts     = 2'd0;
        layer_done = 1'b0;
        busy       = (state_q != FILL);
        is_ts1     = (in_src == TS1_SRC);
        accept     = 1'b0;
        last       = (rptr_q == LAST);

        unique case (state_q)
            FILL: begin
                in_ready = is_ts1 ? !full1_q : !full2_q;
                accept   = in_valid && in_ready;
                if (accept && is_ts1) begin
                    m1_en    = 1'b1;
                    m1_we    = 1'b1;
                    m1_addr  = wptr1_q;
                    m1_wdata = in_psum;
                    if (wptr1_q == LAST) full1_d = 1'b1;
                    else                 wptr1_d = wptr1_q + 1'b1;
                end
                if (accept && !is_ts1) begin
                    m2_en    = 1'b1;
                    m2_we    = 1'b1;
                    m2_addr  = wptr2_q;
                    m2_wdata = in_psum;
                    if (wptr2_q == LAST) full2_d = 1'b1;
                    else                 wptr2_d = wptr2_q + 1'b1;
                end
                // Use next-state flags so the completing write and the
                // hand-off to the scan share one cycle.
                if (full1_d && full2_d) begin
                    state_d = RD1;
                    rptr_d  = '0;
                end
            end
            RD1: begin
                m1_en   = 1'b1;
                state_d = EV1;
            end
            EV1: begin
                val_d   = {1'b0, m1_rdata};
                state_d = OUT1;
            end
            OUT1: begin
                spk_valid = 1'b1;
                spk_ts    = 2'd1;
                if (spk_ready) begin
                    m1_en = 1'b1;
                    m1_we = 1'b1;
                    if (last) begin
                        rptr_d  = '0;
                        state_d = RD2;
                    end else begin
                        rptr_d  = rptr_q + 1'b1;
                        state_d = RD1;
                    end
                end
            end
            RD2: begin
                m1_en   = 1'b1;
                m2_en   = 1'b1;
                state_d = EV2;
            end
            EV2: begin
                val_d   = {1'b0, m1_rdata} + {1'b0, m2_rdata};
                state_d = OUT2;
            end
            OUT2: begin
                spk_valid = 1'b1;
                spk_ts    = 2'd2;
                if (spk_ready) begin
                    m2_en = 1'b1;
                    m2_we = 1'b1;
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        rptr_d  = rptr_q + 1'b1;
                        state_d = RD2;
                    end
                end
            end
            DONE: begin
                layer_done = 1'b1;
                full1_d    = 1'b0;
                full2_d    = 1'b0;
                wptr1_d    = '0;
                wptr2_d    = '0;
                rptr_d     = '0;
                state_d    = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            wptr1_q <= '0;
            wptr2_q <= '0;
            rptr_q  <= '0;
            full1_q <= 1'b0;
            full2_q <= 1'b0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr1_q <= wptr1_d;
            wptr2_q <= wptr2_d;
            rptr_q  <= rptr_d;
            full1_q <= full1_d;
            full2_q <= full2_d;
            val_q   <= val_d;
        end
    end

endmodule

// File: tb/tb_output_mem_scheduler.sv
// Bench for output_mem_scheduler: directed vectors on a 4-deep instance and
// a randomized full-depth layer checked against an arithmetic model.
module tb_output_mem_scheduler;

    localparam int AW  = 9;
    localparam int CW  = 13;
    localparam int THR = 64;
    localparam int DL  = 441;
    localparam int SATV = 8191;

    typedef struct packed {
        logic [1:0]    ts;
        logic [AW-1:0] addr;
        logic          b;
    } spk_t;

    // inputs (src, psum); expected spike i; expected m1/m2 at addr i (i<4)
    typedef struct {
        logic [3:0] src;
        int         psum;
        int         ts;
        int         addr;
        int         b;
        int         em1;
        int         em2;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic rst_n;

    logic          in_valid_s, in_ready_s;
    logic [3:0]    in_src_s;
    logic [CW-1:0] in_psum_s;
    logic          m1_en_s, m1_we_s, m2_en_s, m2_we_s;
    logic [AW-1:0] m1_addr_s, m2_addr_s;
    logic [CW-1:0] m1_wdata_s, m1_rdata_s, m2_wdata_s, m2_rdata_s;
    logic          spk_valid_s, spk_ready_s, spk_bit_s;
    logic [AW-1:0] spk_addr_s;
    logic [1:0]    spk_ts_s;
    logic          layer_done_s, busy_s;

    logic          in_valid_l, in_ready_l;
    logic [3:0]    in_src_l;
    logic [CW-1:0] in_psum_l;
    logic          m1_en_l, m1_we_l, m2_en_l, m2_we_l;
    logic [AW-1:0] m1_addr_l, m2_addr_l;
    logic [CW-1:0] m1_wdata_l, m1_rdata_l, m2_wdata_l, m2_rdata_l;
    logic          spk_valid_l, spk_ready_l, spk_bit_l;
    logic [AW-1:0] spk_addr_l;
    logic [1:0]    spk_ts_l;
    logic          layer_done_l, busy_l;

    output_mem_scheduler #(
        .DEPTH_C(4), .ADDR_C(AW), .CONV_W(CW),
        .THRESHOLD(THR), .TS1_SRC(4'd13)
    ) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s), .in_ready(in_ready_s),
        .in_src(in_src_s), .in_psum(in_psum_s),
        .m1_en(m1_en_s), .m1_we(m1_we_s), .m1_addr(m1_addr_s),
        .m1_wdata(m1_wdata_s), .m1_rdata(m1_rdata_s),
        .m2_en(m2_en_s), .m2_we(m2_we_s), .m2_addr(m2_addr_s),
        .m2_wdata(m2_wdata_s), .m2_rdata(m2_rdata_s),
        .spk_valid(spk_valid_s), .spk_ready(spk_ready_s),
        .spk_addr(spk_addr_s), .spk_bit(spk_bit_s), .spk_ts(spk_ts_s),
        .layer_done(layer_done_s), .busy(busy_s)
    );

    output_mem_scheduler dut_l (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_l), .in_ready(in_ready_l),
        .in_src(in_src_l), .in_psum(in_psum_l),
        .m1_en(m1_en_l), .m1_we(m1_we_l), .m1_addr(m1_addr_l),
        .m1_wdata(m1_wdata_l), .m1_rdata(m1_rdata_l),
        .m2_en(m2_en_l), .m2_we(m2_we_l), .m2_addr(m2_addr_l),
        .m2_wdata(m2_wdata_l), .m2_rdata(m2_rdata_l),
        .spk_valid(spk_valid_l), .spk_ready(spk_ready_l),
        .spk_addr(spk_addr_l), .spk_bit(spk_bit_l), .spk_ts(spk_ts_l),
        .layer_done(layer_done_l), .busy(busy_l)
    );

    logic [CW-1:0] mem1_s [0:511];
    logic [CW-1:0] mem2_s [0:511];
    logic [CW-1:0] mem1_l [0:511];
    logic [CW-1:0] mem2_l [0:511];
    logic          poke_s = 1'b0;

    spk_t q_s[$];
    spk_t q_l[$];
    int   done_s = 0, done_l = 0, w1_s = 0;
    int   acc_cyc_s = 0, done_cyc_s = 0;

    // SRAM models, spike and event monitors
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m1_en_s) begin
            if (m1_we_s) mem1_s[m1_addr_s] <= m1_wdata_s;
            else         m1_rdata_s <= mem1_s[m1_addr_s];
        end
        if (poke_s) mem1_s[0] <= 13'h1fff;
        if (m2_en_s) begin
            if (m2_we_s) mem2_s[m2_addr_s] <= m2_wdata_s;
            else         m2_rdata_s <= mem2_s[m2_addr_s];
        end
        if (m1_en_l) begin
            if (m1_we_l) mem1_l[m1_addr_l] <= m1_wdata_l;
            else         m1_rdata_l <= mem1_l[m1_addr_l];
        end
        if (m2_en_l) begin
            if (m2_we_l) mem2_l[m2_addr_l] <= m2_wdata_l;
            else         m2_rdata_l <= mem2_l[m2_addr_l];
        end
        if (m1_en_s && m1_we_s) w1_s <= w1_s + 1;
        if (in_valid_s && in_ready_s) acc_cyc_s <= cyc;
        if (layer_done_s) begin
            done_s     <= done_s + 1;
            done_cyc_s <= cyc;
        end
        if (layer_done_l) done_l <= done_l + 1;
        if (spk_valid_s && spk_ready_s)
            q_s.push_back({spk_ts_s, spk_addr_s, spk_bit_s});
        if (spk_valid_l && spk_ready_l)
            q_l.push_back({spk_ts_l, spk_addr_l, spk_bit_l});
    end

    vec_t vt[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send_s(input logic [3:0] src, input int p);
        int n;
        n = 0;
        @(negedge clk);
        in_valid_s = 1'b1;
        in_src_s   = src;
        in_psum_s  = CW'(p);
        #1;
        while (!in_ready_s && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        @(negedge clk);
        in_valid_s = 1'b0;
    endtask

    task automatic wait_done_s(input int d0);
        int n;
        n = 0;
        while (done_s == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (done_s == d0) chk("done_timeout", 0, 1);
    endtask

    task automatic run_vec(input string tag);
        int   base, d0;
        spk_t e;
        base = q_s.size();
        d0   = done_s;
        for (int i = 0; i < 8; i++) send_s(vt[i].src, vt[i].psum);
        wait_done_s(d0);
        repeat (2) @(negedge clk);
        chk({tag, "_nspk"}, q_s.size() - base, 8);
        if (q_s.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) begin
                e = {2'(vt[i].ts), AW'(vt[i].addr), vt[i].b[0]};
                chk($sformatf("%s_spk%0d", tag, i),
                    int'(q_s[base+i]), int'(e));
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_m1_%0d", tag, i), int'(mem1_s[i]), vt[i].em1);
            chk($sformatf("%s_m2_%0d", tag, i), int'(mem2_s[i]), vt[i].em2);
        end
        chk({tag, "_done"}, done_s - d0, 1);
        chk({tag, "_lat"}, done_cyc_s - acc_cyc_s, 6 * 4 + 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base, d0, n, bad, seen, busy_seen, w0;
        logic b;
        int   p1[DL], p2[DL], r1[DL], r2[DL], b1[DL], b2[DL];
        int   i1, i2, s, rdy;
        spk_t e;

        vt[0] = '{4'd13, 70, 1, 0, 1,  6, 7};
        vt[1] = '{4'd5,   1, 1, 1, 0, 10, 6};
        vt[2] = '{4'd13, 10, 1, 2, 1,  0, 0};
        vt[3] = '{4'd5,  60, 1, 3, 0, 63, 7};
        vt[4] = '{4'd13, 64, 2, 0, 0,  0, 0};
        vt[5] = '{4'd5,   0, 2, 1, 1,  0, 0};
        vt[6] = '{4'd13, 63, 2, 2, 0,  0, 0};
        vt[7] = '{4'd5,   8, 2, 3, 1,  0, 0};

        rst_n = 1'b0;
        in_valid_s = 1'b0; in_src_s = 4'd13; in_psum_s = '0;
        spk_ready_s = 1'b1;
        in_valid_l = 1'b0; in_src_l = 4'd13; in_psum_l = '0;
        spk_ready_l = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_s, 0);
        chk("rst_spk_valid", spk_valid_s, 0);
        chk("rst_layer_done", layer_done_s, 0);
        chk("rst_m1_en", m1_en_s, 0);
        chk("rst_m2_en", m2_en_s, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready_s, 1);

        // basic layer
        run_vec("basic");

        // stall at ts1 addr 3, poke m1[0] to max to exercise saturation
        base = q_s.size();
        d0   = done_s;
        send_s(4'd13, 8191); send_s(4'd5, 8191);
        send_s(4'd13, 5);    send_s(4'd5, 0);
        send_s(4'd13, 100);  send_s(4'd5, 0);
        send_s(4'd13, 64);   send_s(4'd5, 0);
        spk_ready_s = 1'b0;
        seen = 0;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (spk_valid_s && spk_ts_s == 2'd1 && spk_addr_s == AW'(3))
                seen = 1;
            else
                spk_ready_s = spk_valid_s;
        end
        chk("stall_reach", seen, 1);
        poke_s = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            poke_s = 1'b0;
            chk("stall_valid", spk_valid_s, 1);
            chk("stall_addr", int'(spk_addr_s), 3);
            chk("stall_bit", spk_bit_s, 1);
            chk("stall_ts", int'(spk_ts_s), 1);
            chk("stall_m_en", {m1_en_s, m2_en_s}, 0);
        end
        spk_ready_s = 1'b1;
        wait_done_s(d0);
        repeat (2) @(negedge clk);
        chk("sat_nspk", q_s.size() - base, 8);
        if (q_s.size() >= base + 8) begin
            e = {2'd2, AW'(0), 1'b1};
            chk("sat_spk_ts2_a0", int'(q_s[base+4]), int'(e));
            e = {2'd1, AW'(3), 1'b1};
            chk("stall_spk_once", int'(q_s[base+3]), int'(e));
            e = {2'd2, AW'(1), 1'b0};
            chk("sat_spk_ts2_a1", int'(q_s[base+5]), int'(e));
        end
        chk("sat_m2_0", int'(mem2_s[0]), SATV);
        chk("sat_m2_1", int'(mem2_s[1]), 5);
        chk("sat_m2_2", int'(mem2_s[2]), 36);
        chk("sat_m2_3", int'(mem2_s[3]), 0);

        // ts1 full: further src13 psums stall until DONE
        d0 = done_s;
        for (int k = 1; k <= 4; k++) send_s(4'd13, k);
        @(negedge clk);
        in_valid_s = 1'b1; in_src_s = 4'd13; in_psum_s = CW'(99);
        w0 = w1_s;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (in_ready_s) bad++;
            @(negedge clk);
        end
        chk("full_stall_ready", bad, 0);
        chk("full_no_m1_write", w1_s - w0, 0);
        chk("full_still_fill", busy_s, 0);
        in_valid_s = 1'b0;
        for (int k = 5; k <= 8; k++) send_s(4'd5, k);
        @(negedge clk);
        in_valid_s = 1'b1; in_src_s = 4'd13; in_psum_s = CW'(99);
        bad = 0; busy_seen = 0; n = 0;
        while (done_s == d0 && n < 500) begin
            #1;
            if (busy_s) busy_seen++;
            if (busy_s && in_ready_s) bad++;
            @(negedge clk);
            n++;
        end
        chk("scan_done", done_s - d0, 1);
        chk("scan_ready_low", bad, 0);
        chk("scan_busy_cycles", busy_seen, 6 * 4);
        @(negedge clk);
        in_valid_s = 1'b0;
        @(negedge clk);
        chk("post_done_accept", int'(mem1_s[0]), 99);

        // reset during RD2 at rptr 2
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send_s(vt[i].src, vt[i].psum);
        seen = 0; n = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (m2_en_s && !m2_we_s && m2_addr_s == AW'(2)) seen = 1;
        end
        chk("rd2_reach", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_s, 0);
        chk("arst_spk_valid", spk_valid_s, 0);
        chk("arst_layer_done", layer_done_s, 0);
        chk("arst_m_en", {m1_en_s, m2_en_s, m1_we_s, m2_we_s}, 0);
        chk("arst_in_ready", in_ready_s, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("after_rst");

        // randomized full-depth layer
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DL; i++) begin
            p1[i] = ($urandom % 4 == 0) ? $urandom_range(0, 8191)
                                        : $urandom_range(0, 150);
            p2[i] = ($urandom % 4 == 0) ? $urandom_range(0, 8191)
                                        : $urandom_range(0, 150);
            b1[i] = (p1[i] >= THR) ? 1 : 0;
            r1[i] = p1[i] - b1[i] * THR;
            s     = r1[i] + p2[i];
            b2[i] = (s >= THR) ? 1 : 0;
            r2[i] = s - b2[i] * THR;
            if (r2[i] > SATV) r2[i] = SATV;
        end
        base = q_l.size();
        d0 = done_l;
        i1 = 0; i2 = 0; n = 0;
        while ((i1 < DL || i2 < DL) && n < 20000) begin
            @(negedge clk);
            n++;
            if ($urandom % 10 < 3) begin
                in_valid_l = 1'b0;
            end else if (i1 < DL && (i2 >= DL || $urandom % 2 == 1)) begin
                in_valid_l = 1'b1; in_src_l = 4'd13; in_psum_l = CW'(p1[i1]);
            end else begin
                in_valid_l = 1'b1; in_src_l = 4'd5; in_psum_l = CW'(p2[i2]);
            end
            #1;
            rdy = in_ready_l;
            if (in_valid_l && rdy) begin
                if (in_src_l == 4'd13) i1++;
                else                   i2++;
            end
        end
        @(negedge clk);
        in_valid_l = 1'b0;
        chk("rnd_fill", i1 + i2, 2 * DL);
        n = 0;
        while (done_l == d0 && n < 20000) begin
            @(negedge clk);
            spk_ready_l = ($urandom % 4 != 0);
            n++;
        end
        spk_ready_l = 1'b1;
        repeat (2) @(negedge clk);
        chk("rnd_done", done_l - d0, 1);
        chk("rnd_nspk", q_l.size() - base, 2 * DL);
        if (q_l.size() >= base + 2 * DL) begin
            for (int k = 0; k < 2 * DL; k++) begin
                if (k < DL) e = {2'd1, AW'(k), b1[k][0]};
                else        e = {2'd2, AW'(k - DL), b2[k-DL][0]};
                chk($sformatf("rnd_spk%0d", k), int'(q_l[base+k]), int'(e));
            end
        end
        for (int i = 0; i < DL; i++) begin
            chk($sformatf("rnd_m1_%0d", i), int'(mem1_l[i]), r1[i]);
            chk($sformatf("rnd_m2_%0d", i), int'(mem2_l[i]), r2[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
